vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares the single-port 32Kx16 video RAM between the VGA display fetch path (vgad_addr/vgad_data)
//  and CPU load/store accesses. Display reads have fixed priority and fixed latency; CPU gets idle
//  slots, with a starvation guard forcing a CPU slot after MAX_WAIT denied cycles. One RAM access/cycle.
// PARAMETERS
//  ADDR_W    15  VRAM word-address width
//  DATA_W    16  VRAM data width
//  MAX_WAIT   8  consecutive denied CPU cycles before a forced CPU slot (1..255)
// PORTS
//  clk         in   1       system clock; all logic on rising edge
//  reset       in   1       asynchronous, active-low reset
//  enable      in   1       1 = arbitration active; 0 = no new grants, in-flight access completes
//  disp_req    in   1       display read strobe, one cycle per fetch
//  vgad_addr   in   ADDR_W  display word address, valid with disp_req
//  vgad_data   out  DATA_W  display read data, registered, held until next display fetch returns
//  disp_miss   out  1       1-cycle pulse: display fetch dropped by forced CPU slot
//  cpu_req     in   1       CPU request, level, held until cpu_ack
//  cpu_we      in   1       1 = write, 0 = read; stable while cpu_req
//  cpu_addr    in   ADDR_W  CPU word address; stable while cpu_req
//  cpu_wdata   in   DATA_W  CPU write data; stable while cpu_req
//  cpu_rdata   out  DATA_W  CPU read data, valid with cpu_ack on reads
//  cpu_ack     out  1       1-cycle completion pulse
//  ram_en      out  1       RAM port enable (combinational from grant)
//  ram_we      out  1       RAM write enable
//  ram_addr    out  ADDR_W  RAM address
//  ram_wdata   out  DATA_W  RAM write data
//  ram_rdata   in   DATA_W  RAM read data, valid cycle after ram_en (sync-read BRAM)
//  disp_miss_cnt out 16     stats (see CONFIGURATION)
//  cpu_wait_cnt  out 16     stats (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset=0, async): all outputs 0, CPU FSM C_IDLE, wait counter 0, rd_owner tag NONE.
//  - Grant per cycle N (enable=1): FORCE = (wait_cnt==MAX_WAIT) && cpu_req && C_IDLE.
//    FORCE -> CPU; else disp_req -> DISP; else cpu_req && C_IDLE -> CPU; else none (ram_en=0).
//  - ram_* driven combinationally from the granted source; rd_owner tag registered at end of N.
//  - Display: disp_req in N granted -> ram_rdata in N+1 -> vgad_data updates at end of N+1 (latency 2).
//    If FORCE steals the slot: vgad_data unchanged, disp_miss=1 in N+1.
//  - CPU FSM: C_IDLE -grant,we=1-> C_ACK; C_IDLE -grant,we=0-> C_RD; C_RD -> C_ACK (capture
//    ram_rdata into cpu_rdata); C_ACK -> C_IDLE, cpu_ack=1 for that cycle. Write ack at N+1, read at N+2.
//    CPU must drop or change cpu_req the cycle after cpu_ack; no regrant while not C_IDLE.
//  - wait_cnt: +1 each cycle cpu_req && C_IDLE && no CPU grant (saturates at MAX_WAIT);
//    cleared on CPU grant or cpu_req=0. After FORCE, display again has priority.
//  - Simultaneous disp_req and CPU write to same address: display reads old data (BRAM read-first).
//  - enable=0: ram_en=0 for new requests, wait_cnt held, pending C_RD/C_ACK still complete.
//  - reset mid-access: access abandoned, no ack, vgad_data cleared to 0.
// CONFIGURATION
//  VRAM_ARB_STATS_EN defined: disp_miss_cnt +1 per disp_miss, cpu_wait_cnt +1 per denied CPU cycle,
//    both 16-bit saturating at 16'hFFFF, cleared by reset only.
//  Not defined: counters not built, both ports tied to 0.
// STRUCTURE
//  Package vram_arb_pkg: cpu FSM state enum (C_IDLE,C_RD,C_ACK), rd_owner tag (NONE,DISP,CPU),
//    default widths. Sub-module vram_arb_starve_ctr: saturating wait counter + FORCE compare.
// TESTING
//  1 disp_req alone, addr 0x0010, RAM[0x10]=0xBEEF -> vgad_data=0xBEEF 2 cycles later, cpu_ack never.
//  2 CPU write 0x1234 to 0x7FFF, no display -> ram_we=1 same cycle, cpu_ack at +1; readback ack at +2 =0x1234.
//  3 disp_req every cycle + cpu_req held, MAX_WAIT=8 -> CPU granted on 9th cycle, disp_miss pulse once,
//    vgad_data holds previous value that cycle.
//  4 disp_req and CPU write to 0x0100 (old 0xAAAA, new 0x5555) same cycle -> display wins, CPU next
//    cycle; later display read of 0x0100 returns 0x5555.
//  5 reset low during C_RD -> all outputs 0 asynchronously, no cpu_ack; after release CPU reissues OK.
//  6 STATS_EN: force 3 misses -> disp_miss_cnt=3; without macro -> counters read 0.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the VRAM arbiter: CPU FSM states, read-owner tag,
// default widths and a saturating increment helper for the statistics counters.
package vram_arb_pkg;

    localparam int ADDR_W_DEF   = 15;
    localparam int DATA_W_DEF   = 16;
    localparam int MAX_WAIT_DEF = 8;
    localparam int STAT_W       = 16;
    localparam int WAIT_W       = 8;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_RD   = 2'd1,
        C_ACK  = 2'd2
    } cpu_state_e;

    // Who owns the RAM read data returning in the next cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_CPU  = 2'd2
    } rd_owner_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [STAT_W-1:0] sat_inc16(input logic [STAT_W-1:0] v);
        logic [STAT_W-1:0] res;
        if (v == 16'hFFFF) begin
            res = v;
        end else begin
            res = v + 16'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/vram_arb_starve_ctr.sv
// CPU starvation guard: counts consecutive cycles an idle, requesting CPU is denied the
// RAM and raises o_force_cpu once the count reaches MAX_WAIT, so the next slot goes to the CPU.
module vram_arb_starve_ctr
    import vram_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_cpu_req,
    input  logic i_cpu_idle,
    input  logic i_disp_req,
    output logic o_force_cpu
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              w_force;
    logic              w_cpu_win;
    logic              w_denied;

    // Force decision and this cycle's CPU win/deny outcome
    always_comb begin
        w_force   = (r_wait_cnt == MAX_WAIT_C) && i_cpu_req && i_cpu_idle;
        w_cpu_win = i_enable && i_cpu_req && i_cpu_idle && (w_force || !i_disp_req);
        w_denied  = i_enable && i_cpu_req && i_cpu_idle && !w_cpu_win;
    end

    // Saturating wait counter, cleared on a CPU grant or when the CPU stops asking
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= 8'd0;
        end else if (!i_cpu_req || w_cpu_win) begin
            r_wait_cnt <= 8'd0;
        end else if (w_denied && (r_wait_cnt != MAX_WAIT_C)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end

    assign o_force_cpu = w_force;

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one sync-read RAM port between display fetches (fixed priority,
// fixed 2-cycle latency) and CPU loads/stores (idle slots plus a forced slot after
// MAX_WAIT denied cycles). Optional statistics counters are built when the macro
// VRAM_ARB_STATS_EN is defined; otherwise the counter ports read 0.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] vgad_addr,
    output logic [DATA_W-1:0] vgad_data,
    output logic              disp_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [STAT_W-1:0] disp_miss_cnt,
    output logic [STAT_W-1:0] cpu_wait_cnt
);

    cpu_state_e        r_state;
    cpu_state_e        w_state_nxt;
    rd_owner_e         r_rd_owner;
    rd_owner_e         w_rd_owner_nxt;
    logic [DATA_W-1:0] r_vgad_data;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_disp_miss;
    logic              w_arb_en;
    logic              w_cpu_idle;
    logic              w_force_cpu;
    logic              w_force_slot;
    logic              w_grant_cpu;
    logic              w_grant_disp;
    logic              w_cpu_ack;

    // Reset also blocks grants so the RAM port is quiet while reset is held
    assign w_arb_en   = enable && reset;
    assign w_cpu_idle = (r_state == C_IDLE);

    vram_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_enable    (w_arb_en),
        .i_cpu_req   (cpu_req),
        .i_cpu_idle  (w_cpu_idle),
        .i_disp_req  (disp_req),
        .o_force_cpu (w_force_cpu)
    );

    // Per-cycle grant: forced CPU slot, else display, else idle CPU
    always_comb begin
        w_force_slot = w_arb_en && w_force_cpu;
        w_grant_cpu  = w_force_slot || (w_arb_en && !disp_req && cpu_req && w_cpu_idle);
        w_grant_disp = w_arb_en && disp_req && !w_force_slot;
    end

    // RAM port driven straight from the granted source
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = {DATA_W{1'b0}};
        if (w_grant_cpu) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_we ? cpu_wdata : {DATA_W{1'b0}};
        end else if (w_grant_disp) begin
            ram_en    = 1'b1;
            ram_addr  = vgad_addr;
        end else begin
            ram_en    = 1'b0;
        end
    end

    // Tag the owner of the read data that returns next cycle
    always_comb begin
        w_rd_owner_nxt = OWN_NONE;
        if (w_grant_disp) begin
            w_rd_owner_nxt = OWN_DISP;
        end else if (w_grant_cpu && !cpu_we) begin
            w_rd_owner_nxt = OWN_CPU;
        end else begin
            w_rd_owner_nxt = OWN_NONE;
        end
    end

    // Display datapath: owner tag, captured fetch data and the miss pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_owner  <= OWN_NONE;
            r_vgad_data <= {DATA_W{1'b0}};
            r_disp_miss <= 1'b0;
        end else begin
            r_rd_owner  <= w_rd_owner_nxt;
            r_disp_miss <= w_force_slot && disp_req;
            if (r_rd_owner == OWN_DISP) begin
                r_vgad_data <= ram_rdata;
            end else begin
                r_vgad_data <= r_vgad_data;
            end
        end
    end

    // CPU FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // CPU FSM next state: writes finish in one cycle, reads wait for the RAM data
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_IDLE: begin
                if (w_grant_cpu) begin
                    w_state_nxt = cpu_we ? C_ACK : C_RD;
                end else begin
                    w_state_nxt = C_IDLE;
                end
            end
            C_RD:    w_state_nxt = C_ACK;
            C_ACK:   w_state_nxt = C_IDLE;
            default: w_state_nxt = C_IDLE;
        endcase
    end

    // CPU FSM outputs: completion pulse while in C_ACK
    always_comb begin
        w_cpu_ack = 1'b0;
        case (r_state)
            C_ACK:   w_cpu_ack = 1'b1;
            default: w_cpu_ack = 1'b0;
        endcase
    end

    // CPU read data captured in the cycle the RAM returns it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_rdata <= {DATA_W{1'b0}};
        end else if (r_state == C_RD) begin
            r_cpu_rdata <= ram_rdata;
        end else begin
            r_cpu_rdata <= r_cpu_rdata;
        end
    end

    assign vgad_data = r_vgad_data;
    assign disp_miss = r_disp_miss;
    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ack   = w_cpu_ack;

`ifdef VRAM_ARB_STATS_EN
    logic [STAT_W-1:0] r_disp_miss_cnt;
    logic [STAT_W-1:0] r_cpu_wait_cnt;
    logic              w_cpu_denied;

    assign w_cpu_denied = w_arb_en && cpu_req && w_cpu_idle && !w_grant_cpu;

    // Saturating statistics: dropped display fetches and denied CPU cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_disp_miss_cnt <= 16'd0;
            r_cpu_wait_cnt  <= 16'd0;
        end else begin
            if (r_disp_miss) begin
                r_disp_miss_cnt <= sat_inc16(r_disp_miss_cnt);
            end else begin
                r_disp_miss_cnt <= r_disp_miss_cnt;
            end
            if (w_cpu_denied) begin
                r_cpu_wait_cnt <= sat_inc16(r_cpu_wait_cnt);
            end else begin
                r_cpu_wait_cnt <= r_cpu_wait_cnt;
            end
        end
    end

    assign disp_miss_cnt = r_disp_miss_cnt;
    assign cpu_wait_cnt  = r_cpu_wait_cnt;
`else
    assign disp_miss_cnt = 16'd0;
    assign cpu_wait_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a sync-read RAM model on the RAM port, expected
// display data / miss pulses / CPU acks queued when stimulus is driven and compared
// on the falling clock edge when the DUT produces them.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        disp_req = 1'b0;
    logic [14:0] vgad_addr = 15'd0;
    logic [15:0] vgad_data;
    logic        disp_miss;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [14:0] cpu_addr = 15'd0;
    logic [15:0] cpu_wdata = 16'd0;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        ram_en;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 16'd0;
    logic [15:0] disp_miss_cnt;
    logic [15:0] cpu_wait_cnt;

    vram_arbiter #(.ADDR_W(15), .DATA_W(16), .MAX_WAIT(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .disp_req      (disp_req),
        .vgad_addr     (vgad_addr),
        .vgad_data     (vgad_data),
        .disp_miss     (disp_miss),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_ack       (cpu_ack),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .disp_miss_cnt (disp_miss_cnt),
        .cpu_wait_cnt  (cpu_wait_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-first synchronous RAM model
    logic [15:0] mem [0:32767];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr];
            if (ram_we) mem[ram_addr] <= ram_wdata;
        end
    end

    typedef struct { int due; logic [15:0] val; } disp_exp_t;
    typedef struct { int due; bit rd; logic [15:0] val; } cpu_exp_t;

    disp_exp_t disp_q[$];
    cpu_exp_t  cpu_q[$];
    int        miss_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic exp_disp(input int due, input logic [15:0] v);
        disp_exp_t e;
        e.due = due;
        e.val = v;
        disp_q.push_back(e);
    endtask

    task automatic exp_cpu(input int due, input bit rd, input logic [15:0] v);
        cpu_exp_t e;
        e.due = due;
        e.rd  = rd;
        e.val = v;
        cpu_q.push_back(e);
    endtask

    // Scoreboard side: compare against whatever is due this cycle
    always @(negedge clk) begin
        disp_exp_t de;
        cpu_exp_t  ce;
        logic      exp_miss;
        exp_miss = 1'b0;
        if (miss_q.size() > 0 && miss_q[0] == cyc) begin
            exp_miss = 1'b1;
            void'(miss_q.pop_front());
        end
        check_eq("disp_miss", 32'(disp_miss), 32'(exp_miss));
        if (disp_q.size() > 0 && disp_q[0].due == cyc) begin
            de = disp_q.pop_front();
            check_eq("vgad_data", 32'(vgad_data), 32'(de.val));
        end
        if (cpu_ack) begin
            if (cpu_q.size() == 0) begin
                check_eq("cpu_ack_spurious", 32'(cpu_ack), 32'(0));
            end else begin
                ce = cpu_q.pop_front();
                check_eq("cpu_ack_cycle", 32'(cyc), 32'(ce.due));
                if (ce.rd) check_eq("cpu_rdata", 32'(cpu_rdata), 32'(ce.val));
            end
        end else if (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
            ce = cpu_q.pop_front();
            check_eq("cpu_ack_missing", 32'(cpu_ack), 32'(1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_req  = 1'b0;
        vgad_addr = 15'd0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 15'd0;
        cpu_wdata = 16'd0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_vgad_data"}, 32'(vgad_data), 32'(0));
        check_eq({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'(0));
        check_eq({tag, "_cpu_ack"}, 32'(cpu_ack), 32'(0));
        check_eq({tag, "_disp_miss"}, 32'(disp_miss), 32'(0));
        check_eq({tag, "_ram_en"}, 32'(ram_en), 32'(0));
        check_eq({tag, "_ram_we"}, 32'(ram_we), 32'(0));
        check_eq({tag, "_miss_cnt"}, 32'(disp_miss_cnt), 32'(0));
        check_eq({tag, "_wait_cnt"}, 32'(cpu_wait_cnt), 32'(0));
    endtask

    // CPU access with no competing display traffic: write acks at +1, read at +2
    task automatic cpu_access(input bit we, input logic [14:0] addr, input logic [15:0] wd,
                              input logic [15:0] exp_rd);
        int lat;
        lat       = we ? 1 : 2;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        exp_cpu(cyc + lat, !we, exp_rd);
        for (int i = 0; i < lat; i++) step();
        step();
        cpu_req = 1'b0;
        step();
    endtask

    // Display every cycle with a CPU write held: 9th cycle is a forced CPU slot
    task automatic forced_run(input int r);
        int          s;
        logic [14:0] base;
        base      = 15'(32'h200 + r * 16);
        s         = cyc;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 15'(32'h300 + r);
        cpu_wdata = 16'(32'h7700 + r);
        exp_cpu(s + 9, 1'b0, 16'd0);
        for (int k = 0; k < 12; k++) begin
            if (k == 10) cpu_req = 1'b0;
            disp_req  = 1'b1;
            vgad_addr = base + 15'(k);
            if (k == 8) begin
                exp_disp(s + 10, 16'(32'hC000 + r * 16 + 7));
                miss_q.push_back(s + 9);
                @(negedge clk);
                check_eq("force_ram_we", 32'(ram_we), 32'(1));
                check_eq("force_ram_addr", 32'(ram_addr), 32'h300 + 32'(r));
            end else begin
                exp_disp(s + k + 2, 16'(32'hC000 + r * 16 + k));
            end
            step();
        end
        idle_inputs();
        repeat (3) step();
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'(i) ^ 16'h5A5A;
        mem[15'h0010] = 16'hBEEF;
        mem[15'h0100] = 16'hAAAA;
        for (int i = 0; i < 64; i++) mem[15'h200 + 15'(i)] = 16'hC000 + 16'(i);

        // Reset state, with requests active to show the port stays quiet
        reset     = 1'b0;
        disp_req  = 1'b1;
        vgad_addr = 15'h0010;
        cpu_req   = 1'b1;
        #3;
        check_outputs_zero("reset");
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        step();

        // 1: lone display fetch, latency 2
        disp_req  = 1'b1;
        vgad_addr = 15'h0010;
        exp_disp(cyc + 2, 16'hBEEF);
        @(negedge clk);
        check_eq("t1_ram_en", 32'(ram_en), 32'(1));
        check_eq("t1_ram_addr", 32'(ram_addr), 32'h10);
        step();
        disp_req = 1'b0;
        repeat (4) step();

        // 2: CPU write then readback at top address
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 15'h7FFF;
        cpu_wdata = 16'h1234;
        exp_cpu(cyc + 1, 1'b0, 16'd0);
        @(negedge clk);
        check_eq("t2_ram_we", 32'(ram_we), 32'(1));
        check_eq("t2_ram_addr", 32'(ram_addr), 32'h7FFF);
        check_eq("t2_ram_wdata", 32'(ram_wdata), 32'h1234);
        step();
        step();
        cpu_req = 1'b0;
        step();
        cpu_access(1'b0, 15'h7FFF, 16'd0, 16'h1234);

        // 3 / 6: three forced CPU slots
        for (int r = 0; r < 3; r++) forced_run(r);
        @(negedge clk);
`ifdef VRAM_ARB_STATS_EN
        check_eq("stat_miss_cnt", 32'(disp_miss_cnt), 32'(3));
        check_eq("stat_wait_cnt", 32'(cpu_wait_cnt), 32'(24));
`else
        check_eq("stat_miss_cnt", 32'(disp_miss_cnt), 32'(0));
        check_eq("stat_wait_cnt", 32'(cpu_wait_cnt), 32'(0));
`endif
        step();

        // 4: display and CPU write to the same address in the same cycle
        disp_req  = 1'b1;
        vgad_addr = 15'h0100;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 15'h0100;
        cpu_wdata = 16'h5555;
        exp_disp(cyc + 2, 16'hAAAA);
        exp_cpu(cyc + 2, 1'b0, 16'd0);
        @(negedge clk);
        check_eq("t4_disp_wins", 32'(ram_we), 32'(0));
        step();
        disp_req = 1'b0;
        @(negedge clk);
        check_eq("t4_cpu_next", 32'(ram_we), 32'(1));
        step();
        step();
        cpu_req = 1'b0;
        step();
        disp_req  = 1'b1;
        vgad_addr = 15'h0100;
        exp_disp(cyc + 2, 16'h5555);
        step();
        disp_req = 1'b0;
        repeat (3) step();

        // enable low: no new grant, display data held
        enable    = 1'b0;
        disp_req  = 1'b1;
        vgad_addr = 15'h0010;
        @(negedge clk);
        check_eq("en0_ram_en", 32'(ram_en), 32'(0));
        step();
        disp_req = 1'b0;
        enable   = 1'b1;
        step();
        @(negedge clk);
        check_eq("en0_vgad_hold", 32'(vgad_data), 32'h5555);
        step();

        // 5: reset while a CPU read sits in C_RD
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 15'h7FFF;
        step();
        #2;
        reset = 1'b0;
        #1;
        check_outputs_zero("t5");
        cpu_req = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        cpu_access(1'b0, 15'h7FFF, 16'd0, 16'h1234);
        repeat (3) step();

        check_eq("disp_q_drained", 32'(disp_q.size()), 32'(0));
        check_eq("cpu_q_drained", 32'(cpu_q.size()), 32'(0));
        check_eq("miss_q_drained", 32'(miss_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
